job_feeder: RTL and testbench
=============================

# job_feeder

Host-side feeder that sits directly upstream of the SHA design core. It collects one 24-word mining job (8 midstate words, then 16 header words) from a host valid/ready stream into a local buffer. It launches the job into the core with a `start_found` pulse followed by a gap-free word stream. It captures the golden nonce when the core raises `sol_claim`, hands that nonce to the host, and answers the core on `sol_response`.

## Interface
Parameters:
- `MID_WORDS`, 8, midstate words per job
- `HEAD_WORDS`, 16, header words per job
- `SEARCH_TIMEOUT`, 32'd0, search cycles before abort; 0 disables the timeout

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `n_rst`  in  1  reset, asynchronous, active-low
- `host_valid`  in  1  host job word valid
- `host_data`  in  32  host job word
- `host_ready`  out  1  feeder accepts a job word
- `start_found`  out  1  one-cycle launch pulse to the core
- `in_data`  out  32  job word stream to the core
- `sol_claim`  in  1  core reports a solution
- `out_data`  in  32  golden nonce from the core
- `sol_response`  out  2  answer to the core: 00 none, 01 accept, 10 abort
- `nonce_valid`  out  1  captured nonce available to the host
- `nonce`  out  32  captured nonce
- `nonce_ready`  in  1  host takes the nonce
- `busy`  out  1  high in every state except LOAD

## Operation
- JOB_WORDS = MID_WORDS + HEAD_WORDS = 24. Word count `wcnt` runs 0..24.
- States: LOAD, LAUNCH, STREAM, SEARCH, REPORT, RESPOND.
- **Host acceptance.** `host_ready` = (`wcnt` < 24) && state != STREAM && state != LAUNCH.
  - A word is written on `host_valid && host_ready`, at buffer index `wcnt`, and `wcnt` increments.
  - The next job may therefore be preloaded during SEARCH, REPORT and RESPOND.
- **LOAD:** when `wcnt` == 24, go to LAUNCH.
- **LAUNCH:** `start_found` = 1 for exactly one cycle, then STREAM. The read pointer clears to 0.
- **STREAM:** `in_data` = buffer[`rptr`], with `rptr` incrementing 0..23 on consecutive cycles.
  - On the cycle `rptr` = 23, go to SEARCH and clear `wcnt` to 0.
  - Outside STREAM, `in_data` = 0.
- **SEARCH:** the timeout counter clears on entry and increments each cycle.
  - If `sol_claim` = 1, latch `out_data` into `nonce` and go to REPORT.
  - Else, if SEARCH_TIMEOUT != 0 and the counter reaches SEARCH_TIMEOUT, drive `sol_response` = 10 for one cycle and go to LOAD.
  - A claim and a timeout in the same cycle: the claim wins.
- **REPORT:** `nonce_valid` = 1 and `nonce` is held stable until `nonce_ready`, then go to RESPOND. `nonce_valid` drops the cycle after the handshake.
- **RESPOND:** `sol_response` = 01 for one cycle, then go to LOAD. If `wcnt` == 24 by then, LOAD passes straight on to LAUNCH the next cycle.
- `sol_claim` is ignored outside SEARCH.
- `out_data` is sampled only on the capture cycle.
- The timeout counter width is 32 bits and saturates; it never wraps.

## Timing
- Reset values:
  - state LOAD, `wcnt` = 0, `rptr` = 0, timeout counter 0.
  - All outputs 0, except `host_ready` = 1.
- Reset mid-operation: everything returns to the reset values immediately (asynchronous). A partial job is discarded.
- **Launch cycles.** Let L be the LAUNCH cycle:
  - cycle L: `start_found` = 1, `in_data` = 0.
  - cycles L+1..L+8: midstate words 0..7.
  - cycles L+9..L+24: header words 8..23.
  - cycle L+25: first SEARCH cycle.
- Minimum job latency: LAUNCH occurs 1 cycle after the 24th word is accepted.
- Claim to `nonce_valid`: 1 cycle (capture edge).
- `nonce_ready` handshake to `sol_response` = 01: 1 cycle.
- `sol_response` is never nonzero for more than one cycle.
- `start_found` and `sol_response` are never both nonzero in the same cycle.

## Structure
- Package `job_feeder_pkg`:
  - state enum `feeder_state_t`
  - response constants `RESP_NONE`, `RESP_ACCEPT`, `RESP_ABORT`
  - `JOB_WORDS` localparam
- Sub-module `job_buffer`: JOB_WORDS×32 register file with one write port (index, enable) and one asynchronous read port.
- The top level holds the FSM, counters and nonce register.

## Test plan
- **Contiguous load and launch.** Load 24 words 0x0000_0001..0x0000_0018 with `host_valid` held high:
  - `host_ready` drops after the 24th word.
  - `start_found` pulses one cycle later.
  - `in_data` reads 1..24 on 24 consecutive cycles.
- **Stalled host.** Same data with `host_valid` toggling every other cycle: the stream to the core is still gap-free and identical; `wcnt` never exceeds 24.
- **Solution return.** In SEARCH, pulse `sol_claim` with `out_data` = 0xDEAD_BEEF:
  - `nonce_valid` = 1 and `nonce` = 0xDEADBEEF, held through 5 cycles of `nonce_ready` = 0.
  - After `nonce_ready`, `sol_response` = 01 for one cycle.
- **Preload during search.** Load job 2 during SEARCH, then complete the claim and response: LAUNCH occurs 2 cycles after `sol_response` = 01, streaming job 2's words.
- **Timeout.** Set SEARCH_TIMEOUT = 100 with no claim:
  - `sol_response` = 10 exactly 100 cycles after SEARCH entry.
  - State returns to LOAD.
  - A claim on the same cycle as the timeout yields REPORT instead.
- **Async reset mid-stream.** Assert `n_rst` = 0 at cycle L+5:
  - All outputs are 0 and `host_ready` = 1 immediately.
  - A fresh job then launches normally.

Source files
------------

// File: rtl/job_feeder_pkg.sv
// Shared types and constants for the job feeder: FSM states, core response
// codes and the default job length.
package job_feeder_pkg;

  localparam int unsigned JOB_WORDS = 24;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_LAUNCH,
    ST_STREAM,
    ST_SEARCH,
    ST_REPORT,
    ST_RESPOND
  } feeder_state_t;

  localparam logic [1:0] RESP_NONE   = 2'b00;
  localparam logic [1:0] RESP_ACCEPT = 2'b01;
  localparam logic [1:0] RESP_ABORT  = 2'b10;

endpackage

// File: rtl/job_buffer.sv
// Job word register file: one synchronous write port, one asynchronous read port.
// No reset: contents are only read after a complete job has been written.
module job_buffer
  import job_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = JOB_WORDS,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/job_feeder.sv
// Feeds one mining job from the host into the SHA core, then captures the
// golden nonce (or aborts on timeout) and answers the core.
module job_feeder
  import job_feeder_pkg::*;
#(
  parameter int unsigned MID_WORDS      = 8,
  parameter int unsigned HEAD_WORDS     = 16,
  parameter logic [31:0] SEARCH_TIMEOUT = 32'd0
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        host_valid,
  input  logic [31:0] host_data,
  output logic        host_ready,
  output logic        start_found,
  output logic [31:0] in_data,
  input  logic        sol_claim,
  input  logic [31:0] out_data,
  output logic [1:0]  sol_response,
  output logic        nonce_valid,
  output logic [31:0] nonce,
  input  logic        nonce_ready,
  output logic        busy
);

  localparam int unsigned JW = MID_WORDS + HEAD_WORDS;
  localparam int unsigned AW = $clog2(JW);
  localparam int unsigned CW = $clog2(JW + 1);
  localparam logic [CW-1:0] WCNT_FULL = CW'(JW);
  localparam logic [AW-1:0] RPTR_LAST = AW'(JW - 1);

  feeder_state_t state, state_next;
  logic [CW-1:0] wcnt;
  logic [AW-1:0] rptr;
  logic [31:0]   tcnt;
  logic [31:0]   rd_data;
  logic          wr_en;
  logic          capture;

  // The next job may be preloaded while the core searches, but never while
  // the buffer is being launched or streamed out.
  assign host_ready = (wcnt < WCNT_FULL) && (state != ST_STREAM) && (state != ST_LAUNCH);
  assign wr_en      = host_valid && host_ready;
  assign busy       = (state != ST_LOAD);
  assign in_data    = (state == ST_STREAM) ? rd_data : 32'd0;

  job_buffer #(
    .DEPTH (JW),
    .WIDTH (32)
  ) u_buffer (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wcnt[AW-1:0]),
    .wdata (host_data),
    .raddr (rptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    start_found  = 1'b0;
    sol_response = RESP_NONE;
    nonce_valid  = 1'b0;
    capture      = 1'b0;
    case (state)
      ST_LOAD: begin
        if (wcnt == WCNT_FULL) state_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        start_found = 1'b1;
        state_next  = ST_STREAM;
      end
      ST_STREAM: begin
        if (rptr == RPTR_LAST) state_next = ST_SEARCH;
      end
      ST_SEARCH: begin
        // A claim beats a timeout landing on the same cycle.
        if (sol_claim) begin
          capture    = 1'b1;
          state_next = ST_REPORT;
        end else if ((SEARCH_TIMEOUT != 32'd0) && (tcnt >= SEARCH_TIMEOUT)) begin
          sol_response = RESP_ABORT;
          state_next   = ST_LOAD;
        end
      end
      ST_REPORT: begin
        nonce_valid = 1'b1;
        if (nonce_ready) state_next = ST_RESPOND;
      end
      ST_RESPOND: begin
        sol_response = RESP_ACCEPT;
        state_next   = ST_LOAD;
      end
      default: state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wcnt  <= '0;
      rptr  <= '0;
      tcnt  <= 32'd0;
      nonce <= 32'd0;
    end else begin
      if ((state == ST_STREAM) && (rptr == RPTR_LAST)) wcnt <= '0;
      else if (wr_en)                                   wcnt <= wcnt + 1'b1;

      if ((state == ST_STREAM) && (rptr != RPTR_LAST)) rptr <= rptr + 1'b1;
      else                                              rptr <= '0;

      // Saturating so a disabled or huge timeout never wraps back to zero.
      if (state != ST_SEARCH)  tcnt <= 32'd0;
      else if (tcnt != '1)     tcnt <= tcnt + 32'd1;

      if (capture) nonce <= out_data;
    end
  end

endmodule

// File: tb/tb_job_feeder.sv
// Directed self-checking bench for job_feeder: load/launch/stream, stalled host,
// solution return, preload during search, timeout, and async reset mid-stream.
module tb_job_feeder;

  logic        clk;
  logic        n_rst;
  logic        host_valid;
  logic [31:0] host_data;
  logic        host_ready;
  logic        start_found;
  logic [31:0] in_data;
  logic        sol_claim;
  logic [31:0] out_data;
  logic [1:0]  sol_response;
  logic        nonce_valid;
  logic [31:0] nonce;
  logic        nonce_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  job_feeder #(
    .MID_WORDS      (8),
    .HEAD_WORDS     (16),
    .SEARCH_TIMEOUT (32'd100)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .host_valid   (host_valid),
    .host_data    (host_data),
    .host_ready   (host_ready),
    .start_found  (start_found),
    .in_data      (in_data),
    .sol_claim    (sol_claim),
    .out_data     (out_data),
    .sol_response (sol_response),
    .nonce_valid  (nonce_valid),
    .nonce        (nonce),
    .nonce_ready  (nonce_ready),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Feed 24 words base+1..base+24; with stall the host idles every other cycle.
  task automatic load_words(input logic [31:0] base, input bit stall);
    int  i  = 0;
    bit  ph = 1'b0;
    while (i < 24) begin
      if (stall && ph) begin
        host_valid = 1'b0;
      end else begin
        host_valid = 1'b1;
        host_data  = base + 32'(i) + 32'd1;
      end
      #1;
      if (host_valid) begin
        chk("host_ready_load", 32'(host_ready), 32'd1);
        i++;
      end
      ph = !ph;
      cyc();
    end
    host_valid = 1'b0;
    host_data  = 32'd0;
  endtask

  // Called in the LAUNCH cycle; returns in the first SEARCH cycle.
  task automatic check_stream(input logic [31:0] base);
    chk("launch_start", 32'(start_found), 32'd1);
    chk("launch_in_data", in_data, 32'd0);
    chk("launch_ready", 32'(host_ready), 32'd0);
    for (int i = 0; i < 24; i++) begin
      cyc();
      chk("stream_word", in_data, base + 32'(i) + 32'd1);
      chk("stream_start", 32'(start_found), 32'd0);
      chk("stream_resp", 32'(sol_response), 32'd0);
    end
    cyc();
    chk("search_in_data", in_data, 32'd0);
    chk("search_ready", 32'(host_ready), 32'd1);
    chk("search_busy", 32'(busy), 32'd1);
  endtask

  // Called in the cycle after the 24th word was taken from an idle LOAD.
  task automatic expect_launch_next();
    chk("full_ready", 32'(host_ready), 32'd0);
    chk("full_start", 32'(start_found), 32'd0);
    cyc();
  endtask

  initial begin
    n_rst       = 1'b0;
    host_valid  = 1'b0;
    host_data   = 32'd0;
    sol_claim   = 1'b0;
    out_data    = 32'd0;
    nonce_ready = 1'b0;
    #1;
    chk("rst_host_ready", 32'(host_ready), 32'd1);
    chk("rst_start", 32'(start_found), 32'd0);
    chk("rst_in_data", in_data, 32'd0);
    chk("rst_resp", 32'(sol_response), 32'd0);
    chk("rst_nonce_valid", 32'(nonce_valid), 32'd0);
    chk("rst_nonce", nonce, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #11;
    n_rst = 1'b1;
    cyc();

    $display("[TB] claim outside SEARCH is ignored");
    sol_claim = 1'b1;
    out_data  = 32'h0000_0055;
    cyc();
    sol_claim = 1'b0;
    out_data  = 32'd0;
    chk("idle_claim_valid", 32'(nonce_valid), 32'd0);
    chk("idle_claim_nonce", nonce, 32'd0);
    chk("idle_claim_busy", 32'(busy), 32'd0);

    $display("[TB] contiguous load and launch");
    load_words(32'd0, 1'b0);
    expect_launch_next();
    check_stream(32'd0);

    $display("[TB] solution return");
    cyc();
    cyc();
    sol_claim = 1'b1;
    out_data  = 32'hDEAD_BEEF;
    #1;
    chk("claim_resp", 32'(sol_response), 32'd0);
    cyc();
    sol_claim = 1'b0;
    out_data  = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) sol_claim = 1'b1;
      else        sol_claim = 1'b0;
      #1;
      chk("report_valid", 32'(nonce_valid), 32'd1);
      chk("report_nonce", nonce, 32'hDEAD_BEEF);
      chk("report_resp", 32'(sol_response), 32'd0);
      cyc();
    end
    sol_claim   = 1'b0;
    nonce_ready = 1'b1;
    #1;
    chk("handshake_valid", 32'(nonce_valid), 32'd1);
    chk("handshake_nonce", nonce, 32'hDEAD_BEEF);
    cyc();
    nonce_ready = 1'b0;
    chk("respond_accept", 32'(sol_response), 32'd1);
    chk("respond_valid", 32'(nonce_valid), 32'd0);
    chk("respond_start", 32'(start_found), 32'd0);
    cyc();
    chk("after_resp", 32'(sol_response), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
    chk("after_ready", 32'(host_ready), 32'd1);

    $display("[TB] stalled host");
    load_words(32'd0, 1'b1);
    expect_launch_next();
    check_stream(32'd0);

    $display("[TB] preload during search");
    load_words(32'h1000_0000, 1'b0);
    chk("preload_full_ready", 32'(host_ready), 32'd0);
    chk("preload_busy", 32'(busy), 32'd1);
    sol_claim = 1'b1;
    out_data  = 32'hCAFE_F00D;
    cyc();
    sol_claim   = 1'b0;
    out_data    = 32'd0;
    nonce_ready = 1'b1;
    #1;
    chk("preload_valid", 32'(nonce_valid), 32'd1);
    chk("preload_nonce", nonce, 32'hCAFE_F00D);
    cyc();
    nonce_ready = 1'b0;
    chk("preload_accept", 32'(sol_response), 32'd1);
    cyc();
    chk("preload_load_start", 32'(start_found), 32'd0);
    chk("preload_load_busy", 32'(busy), 32'd0);
    chk("preload_load_ready", 32'(host_ready), 32'd0);
    cyc();
    check_stream(32'h1000_0000);

    $display("[TB] timeout abort");
    for (int k = 0; k < 100; k++) begin
      chk("timeout_wait_resp", 32'(sol_response), 32'd0);
      cyc();
    end
    chk("timeout_abort", 32'(sol_response), 32'd2);
    chk("timeout_busy", 32'(busy), 32'd1);
    cyc();
    chk("timeout_after_resp", 32'(sol_response), 32'd0);
    chk("timeout_after_busy", 32'(busy), 32'd0);
    chk("timeout_after_valid", 32'(nonce_valid), 32'd0);

    $display("[TB] claim on the timeout cycle");
    load_words(32'h0000_0200, 1'b0);
    expect_launch_next();
    check_stream(32'h0000_0200);
    for (int k = 0; k < 100; k++) cyc();
    sol_claim = 1'b1;
    out_data  = 32'h0BAD_C0DE;
    #1;
    chk("tie_resp", 32'(sol_response), 32'd0);
    cyc();
    sol_claim = 1'b0;
    out_data  = 32'd0;
    chk("tie_valid", 32'(nonce_valid), 32'd1);
    chk("tie_nonce", nonce, 32'h0BAD_C0DE);
    nonce_ready = 1'b1;
    cyc();
    nonce_ready = 1'b0;
    chk("tie_accept", 32'(sol_response), 32'd1);
    cyc();
    chk("tie_after_busy", 32'(busy), 32'd0);

    $display("[TB] async reset mid-stream");
    load_words(32'h0000_0300, 1'b0);
    expect_launch_next();
    chk("rs_launch", 32'(start_found), 32'd1);
    for (int k = 0; k < 5; k++) cyc();
    chk("rs_stream_word", in_data, 32'h0000_0305);
    n_rst = 1'b0;
    #1;
    chk("rs_host_ready", 32'(host_ready), 32'd1);
    chk("rs_start", 32'(start_found), 32'd0);
    chk("rs_in_data", in_data, 32'd0);
    chk("rs_resp", 32'(sol_response), 32'd0);
    chk("rs_valid", 32'(nonce_valid), 32'd0);
    chk("rs_nonce", nonce, 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    #3;
    n_rst = 1'b1;
    cyc();
    load_words(32'h0000_0400, 1'b0);
    expect_launch_next();
    check_stream(32'h0000_0400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
